// File: rtl/bus_master_ctrl.sv
// ============================================================================
// bus_master_ctrl : shared-bus initiator with one-hot slave chip selects.
// Optional hung-access abort enabled by defining BUS_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_master_ctrl #(
   parameter int ADDR_W         = 30,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              m_req,
   input  logic              m_rw,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_wr_data,
   output logic              m_busy,
   output logic              m_done,
   output logic [DATA_W-1:0] m_rd_data,
   output logic              m_err,
   output logic [ADDR_W-1:0] s_addr,
   output logic              s_as_,
   output logic              s_rw,
   output logic [DATA_W-1:0] s_wr_data,
   output logic              s0_cs,
   output logic              s1_cs,
   output logic              s2_cs,
   output logic              s3_cs,
   output logic              s4_cs,
   output logic              s5_cs,
   output logic              s6_cs,
   output logic              s7_cs,
   input  logic              s_ready,
   input  logic [DATA_W-1:0] s_data_i
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        start;
   logic        finish;
   logic        abort;
   logic        timeout_hit;
   logic [7:0]  cs;

   assign {s7_cs, s6_cs, s5_cs, s4_cs, s3_cs, s2_cs, s1_cs, s0_cs} = cs;

`ifdef BUS_TIMEOUT_EN
   // Abort at the end of the TIMEOUT_CYCLES-th ACCESS cycle with no ready.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt;
   logic       err_q;

   assign timeout_hit = (tmo_cnt == TMO_LAST);
   assign m_err       = err_q;

   always_ff @(posedge clk) begin
      if (!reset_) begin
         tmo_cnt <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         err_q <= abort;
         if (start) begin
            tmo_cnt <= 8'd0;
         end else if (state == ACCESS && !s_ready) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign m_err       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      finish    = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (m_req) begin
               start     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            // A ready arriving on the limit cycle still completes normally.
            if (s_ready) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end else if (timeout_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         cs        <= 8'd0;
         s_as_     <= 1'b1;
         s_rw      <= 1'b1;
         s_addr    <= '0;
         s_wr_data <= '0;
         m_busy    <= 1'b0;
         m_done    <= 1'b0;
         m_rd_data <= '0;
      end else begin
         m_done <= finish | abort;
         if (start) begin
            s_addr    <= m_addr;
            s_rw      <= m_rw;
            s_wr_data <= m_wr_data;
            cs        <= 8'd1 << m_addr[ADDR_W-1 -: 3];
            s_as_     <= 1'b0;
            m_busy    <= 1'b1;
         end
         if (finish | abort) begin
            cs     <= 8'd0;
            s_as_  <= 1'b1;
            m_busy <= 1'b0;
            if (s_rw) begin
               m_rd_data <= finish ? s_data_i : '0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_master_ctrl.sv
// ============================================================================
// tb_bus_master_ctrl : randomized self-checking bench with transaction model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_master_ctrl;

   logic        clk = 1'b0;
   logic        reset_;
   logic        m_req;
   logic        m_rw;
   logic [29:0] m_addr;
   logic [31:0] m_wr_data;
   logic        m_busy;
   logic        m_done;
   logic [31:0] m_rd_data;
   logic        m_err;
   logic [29:0] s_addr;
   logic        s_as_;
   logic        s_rw;
   logic [31:0] s_wr_data;
   logic        s0_cs, s1_cs, s2_cs, s3_cs, s4_cs, s5_cs, s6_cs, s7_cs;
   logic        s_ready;
   logic [31:0] s_data_i;
   logic [7:0]  cs_v;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_rd;

   assign cs_v = {s7_cs, s6_cs, s5_cs, s4_cs, s3_cs, s2_cs, s1_cs, s0_cs};

   always #5 clk = ~clk;

   bus_master_ctrl #(.ADDR_W(30), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_(reset_), .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr),
      .m_wr_data(m_wr_data), .m_busy(m_busy), .m_done(m_done), .m_rd_data(m_rd_data),
      .m_err(m_err), .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
      .s0_cs(s0_cs), .s1_cs(s1_cs), .s2_cs(s2_cs), .s3_cs(s3_cs),
      .s4_cs(s4_cs), .s5_cs(s5_cs), .s6_cs(s6_cs), .s7_cs(s7_cs),
      .s_ready(s_ready), .s_data_i(s_data_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cs"}, 64'(cs_v), 64'd0);
      chk({tag, "_as"}, 64'(s_as_), 64'd1);
      chk({tag, "_busy"}, 64'(m_busy), 64'd0);
   endtask

   // One transfer: request, dly wait cycles, then one ready cycle. With
   // drop set, a conflicting request is held during the wait cycles.
   task automatic do_txn(input logic [29:0] a, input logic rw, input logic [31:0] wd,
                         input int dly, input logic [31:0] rd, input bit drop);
      logic [7:0] exp_cs;
      exp_cs    = 8'd1 << a[29:27];
      m_req     = 1'b1;
      m_addr    = a;
      m_rw      = rw;
      m_wr_data = wd;
      s_ready   = 1'b0;
      tick();
      m_req = 1'b0;
      chk("start_cs", 64'(cs_v), 64'(exp_cs));
      chk("start_busy", 64'(m_busy), 64'd1);
      chk("start_as", 64'(s_as_), 64'd0);
      chk("start_addr", 64'(s_addr), 64'(a));
      chk("start_rw", 64'(s_rw), 64'(rw));
      chk("start_wdata", 64'(s_wr_data), 64'(wd));
      chk("start_nodone", 64'(m_done), 64'd0);
      for (int i = 0; i < dly; i++) begin
         if (drop) begin
            m_req  = 1'b1;
            m_addr = ~a;
            m_rw   = ~rw;
         end
         s_ready  = 1'b0;
         s_data_i = $urandom;
         tick();
         chk("hold_cs", 64'(cs_v), 64'(exp_cs));
         chk("hold_addr", 64'(s_addr), 64'(a));
         chk("hold_busy", 64'(m_busy), 64'd1);
         chk("hold_nodone", 64'(m_done), 64'd0);
      end
      m_req    = 1'b0;
      s_ready  = 1'b1;
      s_data_i = rd;
      tick();
      s_ready  = 1'b0;
      s_data_i = $urandom;
      if (rw) exp_rd = rd;
      chk("done_pulse", 64'(m_done), 64'd1);
      chk("done_err", 64'(m_err), 64'd0);
      chk_idle_outputs("done");
      chk("rd_data", 64'(m_rd_data), 64'(exp_rd));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         m_req   = 1'b0;
         s_ready = 1'($urandom);
         tick();
         chk("idle_nodone", 64'(m_done), 64'd0);
         chk_idle_outputs("idle");
      end
      s_ready = 1'b0;
   endtask

   task automatic reset_mid(input logic [29:0] a, input logic rw);
      m_req  = 1'b1;
      m_addr = a;
      m_rw   = rw;
      tick();
      m_req  = 1'b0;
      reset_ = 1'b0;
      tick();
      reset_ = 1'b1;
      exp_rd = 32'd0;
      chk_idle_outputs("rst");
      chk("rst_nodone", 64'(m_done), 64'd0);
      chk("rst_addr", 64'(s_addr), 64'd0);
      chk("rst_rw", 64'(s_rw), 64'd1);
      chk("rst_rd", 64'(m_rd_data), 64'd0);
      tick();
      chk("rst_nodone2", 64'(m_done), 64'd0);
   endtask

   initial begin
      reset_    = 1'b0;
      m_req     = 1'b0;
      m_rw      = 1'b0;
      m_addr    = '0;
      m_wr_data = '0;
      s_ready   = 1'b0;
      s_data_i  = '0;
      exp_rd    = 32'd0;
      tick();
      tick();
      chk_idle_outputs("reset");
      chk("reset_done", 64'(m_done), 64'd0);
      chk("reset_err", 64'(m_err), 64'd0);
      chk("reset_rd", 64'(m_rd_data), 64'd0);
      chk("reset_saddr", 64'(s_addr), 64'd0);
      chk("reset_rw", 64'(s_rw), 64'd1);
      chk("reset_wdata", 64'(s_wr_data), 64'd0);
      reset_ = 1'b1;
      idle(2);

      // Read from slave 2 with delayed ready, then write to slave 7.
      do_txn(30'h1000_0004, 1'b1, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
      idle(1);
      do_txn(30'h3800_0000, 1'b0, 32'h1234_5678, 0, 32'h5555_AAAA, 1'b0);
      // Back-to-back: slaves 0 then 1, immediate ready.
      do_txn(30'h0000_0010, 1'b1, 32'h0, 0, 32'hA5A5_0001, 1'b0);
      do_txn(30'h0800_0020, 1'b1, 32'h0, 0, 32'hA5A5_0002, 1'b0);
      idle(1);
      // Conflicting request while busy must be dropped.
      do_txn(30'h2000_0100, 1'b1, 32'h0, 3, 32'hCAFE_F00D, 1'b1);
      idle(2);

      // Hung access: abort when enabled, otherwise still outstanding.
      m_req  = 1'b1;
      m_addr = 30'h1800_0008;
      m_rw   = 1'b1;
      tick();
      m_req = 1'b0;
`ifdef BUS_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("tmo_wait", 64'(m_done), 64'd0);
      end
      tick();
      exp_rd = 32'd0;
      chk("tmo_done", 64'(m_done), 64'd1);
      chk("tmo_err", 64'(m_err), 64'd1);
      chk("tmo_rd", 64'(m_rd_data), 64'd0);
      chk_idle_outputs("tmo");
      tick();
      chk("tmo_err_once", 64'(m_err), 64'd0);
`else
      for (int i = 0; i < 1000; i++) tick();
      chk("hang_busy", 64'(m_busy), 64'd1);
      chk("hang_nodone", 64'(m_done), 64'd0);
      chk("hang_cs", 64'(cs_v), 64'h08);
      s_ready  = 1'b1;
      s_data_i = 32'h0BAD_CAFE;
      tick();
      s_ready = 1'b0;
      exp_rd  = 32'h0BAD_CAFE;
      chk("hang_done", 64'(m_done), 64'd1);
      chk("hang_rd", 64'(m_rd_data), 64'(exp_rd));
      chk("hang_err", 64'(m_err), 64'd0);
`endif
      idle(1);

      reset_mid(30'h2800_0040, 1'b1);
      do_txn(30'h3000_0044, 1'b1, 32'h0, 1, 32'h7777_1234, 1'b0);

      for (int t = 0; t < 200; t++) begin
         int sel;
         sel = int'($urandom_range(0, 19));
         if (sel == 0) begin
            reset_mid(30'($urandom), 1'($urandom));
         end else begin
            do_txn(30'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)),
                   $urandom, (sel < 5));
         end
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
